// File: rtl/vec_unpack_seq.sv
// vec_unpack_seq: writeback-side unpacker for a V-bit result with a 2-bit destination select.
// Select 00 forwards the whole vector in one beat; 01/10/11 serialize it into S-bit lanes
// (ascending) tagged with the scalar destination. One result is in flight at a time.
// Optional feature macro: UNPACK_ZERO_SKIP_EN (skip all-zero lanes on the scalar path).
module vec_unpack_seq #(
  parameter int unsigned S = 32,
  parameter int unsigned V = 192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [V-1:0]          in_data,
  input  logic [1:0]            in_sel,
  output logic                  vec_valid,
  input  logic                  vec_ready,
  output logic [V-1:0]          vec_data,
  output logic                  sc_valid,
  input  logic                  sc_ready,
  output logic [S-1:0]          sc_data,
  output logic [$clog2(V/S)-1:0] sc_lane,
  output logic [1:0]            sc_dest,
  output logic                  sc_last,
  output logic                  busy
);

  localparam int unsigned Lanes = V / S;
  localparam int unsigned LaneW = $clog2(V / S);

  typedef enum logic [1:0] {StIdle, StVec, StScal} state_e;

  state_e             state_q, state_d;
  logic [V-1:0]       buf_q, buf_d;
  logic [1:0]         dsel_q, dsel_d;
  logic [LaneW-1:0]   lane_q, lane_d;
  logic               accept;
  logic               last_beat;

`ifdef UNPACK_ZERO_SKIP_EN
  logic [Lanes-1:0]   mask_q, mask_d;
  logic [Lanes-1:0]   in_mask;
  logic [Lanes-1:0]   rem_mask;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [LaneW-1:0] low_idx(input logic [Lanes-1:0] m);
    logic [LaneW-1:0] r;
    r = '0;
    for (int i = int'(Lanes) - 1; i >= 0; i--) begin
      if (m[i]) r = LaneW'(i);
    end
    return r;
  endfunction

  // Per-lane nonzero flags of the incoming vector, and lanes still to emit after this one.
  always_comb begin
    for (int i = 0; i < int'(Lanes); i++) begin
      in_mask[i] = |in_data[i*S +: S];
    end
    rem_mask         = mask_q;
    rem_mask[lane_q] = 1'b0;
  end

  assign last_beat = (rem_mask == '0);
  assign sc_valid  = (state_q == StScal) && (mask_q != '0);
`else
  assign last_beat = (lane_q == LaneW'(Lanes - 1));
  assign sc_valid  = (state_q == StScal);
`endif

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign accept    = in_valid && in_ready;
  assign vec_valid = (state_q == StVec);
  assign vec_data  = buf_q;
  assign sc_data   = buf_q[int'(lane_q)*S +: S];
  assign sc_lane   = lane_q;
  assign sc_dest   = dsel_q;
  assign sc_last   = sc_valid && last_beat;

  // Next-state logic: capture on accept, release on the final output handshake.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    dsel_d  = dsel_q;
    lane_d  = lane_q;
`ifdef UNPACK_ZERO_SKIP_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          buf_d  = in_data;
          dsel_d = in_sel;
          if (in_sel == 2'b00) begin
            state_d = StVec;
          end else begin
            state_d = StScal;
`ifdef UNPACK_ZERO_SKIP_EN
            mask_d  = in_mask;
            lane_d  = low_idx(in_mask);
`else
            lane_d  = '0;
`endif
          end
        end
      end
      StVec: begin
        if (vec_ready) state_d = StIdle;
      end
      StScal: begin
`ifdef UNPACK_ZERO_SKIP_EN
        // An all-zero scalar result emits nothing and frees the block after one cycle.
        if (mask_q == '0) begin
          state_d = StIdle;
        end else if (sc_ready) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            lane_d = low_idx(rem_mask);
            mask_d = rem_mask;
          end
        end
`else
        if (sc_ready) begin
          if (last_beat) state_d = StIdle;
          else           lane_d  = lane_q + LaneW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset that aborts any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      buf_q   <= '0;
      dsel_q  <= '0;
      lane_q  <= '0;
`ifdef UNPACK_ZERO_SKIP_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      dsel_q  <= dsel_d;
      lane_q  <= lane_d;
`ifdef UNPACK_ZERO_SKIP_EN
      mask_q  <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_vec_unpack_seq.sv
// Testbench for vec_unpack_seq: table-driven results plus reset-abort and back-to-back sequences.
module tb_vec_unpack_seq;

  localparam int S = 32;
  localparam int V = 192;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [V-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           vec_valid;
  logic           vec_ready;
  logic [V-1:0]   vec_data;
  logic           sc_valid;
  logic           sc_ready;
  logic [S-1:0]   sc_data;
  logic [2:0]     sc_lane;
  logic [1:0]     sc_dest;
  logic           sc_last;
  logic           busy;

  int checks = 0;
  int errors = 0;

  vec_unpack_seq #(.S(S), .V(V)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .sc_valid  (sc_valid),
    .sc_ready  (sc_ready),
    .sc_data   (sc_data),
    .sc_lane   (sc_lane),
    .sc_dest   (sc_dest),
    .sc_last   (sc_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       sel;
    logic [5:0][31:0] lanes;
    bit               stall;
  } item_t;

  item_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Offer one result, then walk through every expected output beat.
  task automatic run_item(input item_t t);
    logic [5:0] emit;
    int         last_i;
    int         beat;
    emit = 6'h3f;
`ifdef UNPACK_ZERO_SKIP_EN
    for (int i = 0; i < 6; i++) emit[i] = (t.lanes[i] != 32'h0);
`endif
    last_i = -1;
    for (int i = 0; i < 6; i++) if (emit[i]) last_i = i;

    check("idle_in_ready", {191'h0, in_ready}, 192'h1);
    in_valid = 1'b1;
    in_sel   = t.sel;
    in_data  = t.lanes;
    step();
    in_valid = 1'b0;

    if (t.sel == 2'b00) begin
      if (t.stall) begin
        vec_ready = 1'b0;
        step();
        check("vec_stall_valid", {191'h0, vec_valid}, 192'h1);
        check("vec_stall_data", vec_data, t.lanes);
        vec_ready = 1'b1;
      end
      check("vec_valid", {191'h0, vec_valid}, 192'h1);
      check("vec_data", vec_data, t.lanes);
      check("vec_sc_valid", {191'h0, sc_valid}, 192'h0);
      check("vec_in_ready", {191'h0, in_ready}, 192'h0);
      check("vec_busy", {191'h0, busy}, 192'h1);
      step();
      check("vec_done_valid", {191'h0, vec_valid}, 192'h0);
    end else if (last_i < 0) begin
      check("zero_busy", {191'h0, busy}, 192'h1);
      check("zero_sc_valid", {191'h0, sc_valid}, 192'h0);
      check("zero_in_ready", {191'h0, in_ready}, 192'h0);
      step();
    end else begin
      beat = 0;
      for (int i = 0; i < 6; i++) begin
        if (emit[i]) begin
          if (t.stall && (beat % 2 == 1)) begin
            sc_ready = 1'b0;
            for (int k = 0; k < 2; k++) begin
              check("stall_sc_valid", {191'h0, sc_valid}, 192'h1);
              check("stall_sc_lane", {189'h0, sc_lane}, 192'(i));
              check("stall_sc_data", {160'h0, sc_data}, {160'h0, t.lanes[i]});
              check("stall_sc_last", {191'h0, sc_last}, {191'h0, (i == last_i)});
              check("stall_in_ready", {191'h0, in_ready}, 192'h0);
              step();
            end
            sc_ready = 1'b1;
          end
          check("sc_valid", {191'h0, sc_valid}, 192'h1);
          check("sc_data", {160'h0, sc_data}, {160'h0, t.lanes[i]});
          check("sc_lane", {189'h0, sc_lane}, 192'(i));
          check("sc_dest", {190'h0, sc_dest}, {190'h0, t.sel});
          check("sc_last", {191'h0, sc_last}, {191'h0, (i == last_i)});
          check("sc_vec_valid", {191'h0, vec_valid}, 192'h0);
          check("sc_in_ready", {191'h0, in_ready}, 192'h0);
          step();
          beat++;
        end
      end
    end
    check("done_sc_valid", {191'h0, sc_valid}, 192'h0);
    check("done_in_ready", {191'h0, in_ready}, 192'h1);
    check("done_busy", {191'h0, busy}, 192'h0);
  endtask

  initial begin
    int acc0, acc1, vec_cyc, sc_first, sc_lastc, sc_cnt, n_acc, post_beats;

    tbl[0].sel   = 2'b00;
    tbl[0].lanes = 192'h0123456789ABCDEF_FEDCBA9876543210_0123456789ABCDEF;
    tbl[0].stall = 1'b0;
    tbl[1].sel   = 2'b10;
    for (int i = 0; i < 6; i++) tbl[1].lanes[i] = 32'h1000_0000 + 32'(i);
    tbl[1].stall = 1'b0;
    tbl[2].sel   = 2'b01;
    tbl[2].lanes = 192'hCAFE0005_0BAD0004_FACE0003_BEEF0002_DEAD0001_A5A50000;
    tbl[2].stall = 1'b1;
    tbl[3].sel   = 2'b11;
    tbl[3].lanes = '0;
    tbl[3].lanes[1] = 32'h5;
    tbl[3].lanes[4] = 32'h9;
    tbl[3].stall = 1'b0;
    tbl[4].sel   = 2'b01;
    tbl[4].lanes = '0;
    tbl[4].stall = 1'b0;
    tbl[5].sel   = 2'b00;
    tbl[5].lanes = 192'hFFFF0000_12345678_9ABCDEF0_0F0F0F0F_80000001_7FFFFFFE;
    tbl[5].stall = 1'b1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'b00;
    vec_ready = 1'b1;
    sc_ready  = 1'b1;
    step();
    step();
    check("rst_vec_valid", {191'h0, vec_valid}, 192'h0);
    check("rst_sc_valid", {191'h0, sc_valid}, 192'h0);
    check("rst_sc_last", {191'h0, sc_last}, 192'h0);
    check("rst_busy", {191'h0, busy}, 192'h0);
    check("rst_vec_data", vec_data, 192'h0);
    check("rst_sc_data", {160'h0, sc_data}, 192'h0);
    check("rst_sc_lane", {189'h0, sc_lane}, 192'h0);
    check("rst_sc_dest", {190'h0, sc_dest}, 192'h0);
    check("rst_in_ready", {191'h0, in_ready}, 192'h1);
    rst_n = 1'b1;
    step();

    for (int n = 0; n < 6; n++) run_item(tbl[n]);

    // Reset asserted while lane 3 of a scalar result is on the output.
    in_valid = 1'b1;
    in_sel   = 2'b01;
    in_data  = tbl[1].lanes;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check("pre_rst_lane", {189'h0, sc_lane}, 192'h3);
    rst_n = 1'b0;
    step();
    check("mid_rst_sc_valid", {191'h0, sc_valid}, 192'h0);
    check("mid_rst_busy", {191'h0, busy}, 192'h0);
    check("mid_rst_in_ready", {191'h0, in_ready}, 192'h1);
    check("mid_rst_sc_lane", {189'h0, sc_lane}, 192'h0);
    check("mid_rst_sc_data", {160'h0, sc_data}, 192'h0);
    rst_n = 1'b1;
    post_beats = 0;
    for (int c = 0; c < 8; c++) begin
      if (sc_valid || vec_valid) post_beats++;
      step();
    end
    check("post_rst_beats", 192'(post_beats), 192'h0);

    // Back-to-back: vector then scalar(sel 01), offered continuously with sinks ready.
    acc0 = -1; acc1 = -1; vec_cyc = -1; sc_first = -1; sc_lastc = -1; sc_cnt = 0; n_acc = 0;
    in_valid = 1'b1;
    in_sel   = 2'b00;
    in_data  = tbl[0].lanes;
    for (int c = 0; c < 12; c++) begin
      if (vec_valid && vec_ready && vec_cyc < 0) vec_cyc = c;
      if (sc_valid && sc_ready) begin
        if (sc_first < 0) sc_first = c;
        sc_lastc = c;
        sc_cnt++;
      end
      if (in_valid && in_ready) begin
        if (n_acc == 0) acc0 = c;
        else acc1 = c;
        n_acc++;
      end
      step();
      if (n_acc == 1) begin
        in_sel  = 2'b01;
        in_data = tbl[2].lanes;
      end else if (n_acc >= 2) begin
        in_valid = 1'b0;
      end
    end
    check("b2b_accept0", 192'(acc0), 192'h0);
    check("b2b_accept1", 192'(acc1), 192'h2);
    check("b2b_vec_cycle", 192'(vec_cyc), 192'h1);
    check("b2b_sc_first", 192'(sc_first), 192'h3);
    check("b2b_sc_last", 192'(sc_lastc), 192'h8);
    check("b2b_sc_count", 192'(sc_cnt), 192'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_unpack_seq.md
# vec_unpack_seq

- Writeback-side counterpart of the 2-bit-select scalar/vector result mux.
- Accepts one V-bit result plus its 2-bit destination select over a valid/ready handshake.
- Select 2'b00: forwards the whole vector in one beat to the vector register file.
- Select 2'b01/2'b10/2'b11: serializes the vector into S-bit lanes, one per beat, tagged for scalar destination A/B/C.

## Interface
Parameters:
- S, 32, scalar lane width in bits
- V, 192, vector width in bits; must be an integer multiple of S (LANES = V/S = 6)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a result
- in_ready  out  1  block can accept a result
- in_data  in  V  result vector
- in_sel  in  2  destination: 00 vector, 01 scalar A, 10 scalar B, 11 scalar C
- vec_valid  out  1  vector beat valid
- vec_ready  in  1  vector sink accepts
- vec_data  out  V  captured vector
- sc_valid  out  1  scalar beat valid
- sc_ready  in  1  scalar sink accepts
- sc_data  out  S  current lane
- sc_lane  out  $clog2(LANES)  index of current lane
- sc_dest  out  2  captured in_sel (01/10/11)
- sc_last  out  1  current scalar beat is the final one of this result
- busy  out  1  a result is held (state != IDLE)

## Operation
- FSM states: IDLE, VEC, SCAL.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_data into buf and in_sel into dsel.
  - Go to VEC if in_sel==00; otherwise go to SCAL with lane=0.
- VEC:
  - vec_valid=1 and vec_data=buf.
  - On vec_ready, go to IDLE.
- SCAL:
  - sc_valid=1, sc_data=buf[lane*S +: S], sc_lane=lane, sc_dest=dsel.
  - On sc_ready:
    - If sc_last, go to IDLE.
    - Otherwise lane advances to the next emitted lane.
  - Without the zero-skip feature, sc_last = (lane==LANES-1).
- Lane order is ascending: lane 0 is bits [S-1:0].
- in_ready is 0 in VEC and SCAL. There is no bypass and no skid buffer; one result is in flight at a time.
- sc_valid and vec_valid are never high together. The inactive output's data is held at its last value and is don't-care.
- Once valid is asserted, data, lane, dest and last stay stable until the ready handshake completes (valid is not dropped early).
- Reset (async, any state): state=IDLE, lane=0, buf=0, dsel=0, aborting any in-flight result with no further beats.
- Output values during and after reset: vec_valid=0, sc_valid=0, sc_last=0, busy=0, vec_data=0, sc_data=0, sc_lane=0, sc_dest=0, in_ready=1.

## Timing
- Acceptance at edge N → first output beat valid in cycle N+1 (one-cycle latency).
- Vector result with vec_ready held 1: 2 cycles per result (accept, emit).
- Scalar result with sc_ready held 1: 1 + LANES = 7 cycles per result.
- Backpressure stalls the FSM indefinitely with outputs held.
- The next result can be accepted in the cycle after the final handshake, when the FSM is in IDLE.

## Configuration
- Macro: UNPACK_ZERO_SKIP_EN.
- Undefined: every lane is emitted (LANES beats per scalar result).
- Defined:
  - At acceptance, compute a LANES-bit nonzero mask; lanes whose S-bit value is 0 are not emitted.
  - The first beat is the lowest nonzero lane. lane jumps to the next set mask bit.
  - sc_last=1 when no set mask bit remains above lane.
  - If in_sel!=00 and all lanes are zero: accept, produce no scalar beat, and return to IDLE at the next edge (busy high for one cycle).
  - Vector results (sel 00) are unaffected.

## Test plan
- Reset mid-SCAL: assert rst_n=0 at lane 3 → next cycle sc_valid=0, busy=0, in_ready=1; no further beats after release.
- Vector path: in_sel=00, in_data=192'h0123...CDEF pattern, vec_ready=1 → vec_valid one cycle after accept with matching data; in_ready returns 1 the following cycle.
- Scalar serialization: in_sel=10, lanes i = 32'h1000_0000+i, sc_ready=1 → 6 beats with sc_data=32'h1000_0000..32'h1000_0005, sc_lane 0..5, sc_dest=10, sc_last only on lane 5.
- Backpressure: sc_ready toggles 1,0,0,1,… → each beat held stable while sc_ready=0; no lane skipped or repeated; in_ready stays 0 until the final handshake.
- Back-to-back: a vector then a scalar(sel 01) offered continuously with sinks ready → accept cycles are 0 and 2; scalar beats occupy cycles 3–8.
- UNPACK_ZERO_SKIP_EN: lanes {0,5,0,0,9,0}, sel 11 → beats lane1=5 then lane4=9 (sc_last); an all-zero vector with sel 01 → no sc_valid, busy high for one cycle.
